// File: rtl/pll_ctl_pkg.sv
// Shared definitions for the PLL control blocks: state encoding,
// statistics saturation value and the cycle-counter sizing helper.
package pll_ctl_pkg;

    localparam logic [1:0] ST_RESET_PLL = 2'd0;
    localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
    localparam logic [1:0] ST_STABILIZE = 2'd2;
    localparam logic [1:0] ST_RUN       = 2'd3;

    typedef enum logic [1:0] {
        RESET_PLL = ST_RESET_PLL,
        WAIT_LOCK = ST_WAIT_LOCK,
        STABILIZE = ST_STABILIZE,
        RUN       = ST_RUN
    } pll_state_t;

    localparam logic [7:0] STAT_MAX = 8'hFF;

    // Width of a counter that must reach (largest parameter - 1); never below 1 bit.
    function automatic int counter_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous status inputs; q lags d by two edges.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First flop may go metastable; second flop gives it a full cycle to settle.
    always_ff @(posedge clock) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_monitor.sv
// Sequences the PLL reset, waits for a stable lock and only then releases
// the reset of the logic running from the PLL outputs. Counts lock losses
// and lock timeouts for diagnostics.
module pll_lock_monitor
    import pll_ctl_pkg::*;
#(
    parameter int ARESET_CYCLES = 4,
    parameter int LOCK_TIMEOUT  = 1024,
    parameter int STABLE_CYCLES = 256
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       locked,
    input  logic       force_relock,
    output logic       pll_areset,
    output logic       sys_rst,
    output logic       ready,
    output logic [7:0] lost_lock_count,
    output logic [7:0] timeout_count
);

    localparam int CW = counter_width(ARESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

    localparam logic [CW-1:0] ARESET_LAST  = CW'(ARESET_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);

    pll_state_t    state;
    pll_state_t    next_state;
    logic [CW-1:0] counter;
    logic          locked_s;
    logic          timeout_hit;
    logic          lock_lost;

    sync2 #(.WIDTH(1)) u_lock_sync (
        .clock (clock),
        .rst   (rst),
        .d     (locked),
        .q     (locked_s)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (rst) state <= RESET_PLL;
        else     state <= next_state;
    end

    // Shared cycle counter; a forced relock restarts it so a relock requested
    // during RESET_PLL still produces a full-length PLL reset pulse.
    always_ff @(posedge clock) begin
        if (rst)                                    counter <= '0;
        else if (force_relock || next_state != state) counter <= '0;
        else                                        counter <= counter + CW'(1);
    end

    // Saturating diagnostic counters.
    always_ff @(posedge clock) begin
        if (rst) begin
            lost_lock_count <= '0;
            timeout_count   <= '0;
        end else begin
            if (lock_lost && lost_lock_count != STAT_MAX)
                lost_lock_count <= lost_lock_count + 8'd1;
            if (timeout_hit && timeout_count != STAT_MAX)
                timeout_count <= timeout_count + 8'd1;
        end
    end

    // Next-state logic; a forced relock overrides every other transition but
    // a coincident lock loss in RUN is still counted.
    always_comb begin
        next_state  = state;
        timeout_hit = 1'b0;
        lock_lost   = 1'b0;
        case (state)
            RESET_PLL: begin
                if (counter == ARESET_LAST) next_state = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    next_state = STABILIZE;
                end else if (counter == TIMEOUT_LAST) begin
                    next_state  = RESET_PLL;
                    timeout_hit = 1'b1;
                end
            end
            STABILIZE: begin
                if (!locked_s)                   next_state = WAIT_LOCK;
                else if (counter == STABLE_LAST) next_state = RUN;
            end
            RUN: begin
                if (!locked_s) begin
                    next_state = WAIT_LOCK;
                    lock_lost  = 1'b1;
                end
            end
            default: next_state = RESET_PLL;
        endcase
        if (force_relock) begin
            next_state  = RESET_PLL;
            timeout_hit = 1'b0;
        end
    end

    // Moore outputs decoded straight from the state register.
    always_comb begin
        pll_areset = (state == RESET_PLL);
        sys_rst    = (state != RUN);
        ready      = (state == RUN);
    end

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Bench for pll_lock_monitor with small parameters: a vector table for the
// reset/lock/relock timeline, hand sequences for multi-cycle corner cases,
// and random stimulus checked every cycle against a phase/age model.
module tb_pll_lock_monitor;

    localparam int AR = 4;
    localparam int LT = 16;
    localparam int SC = 8;

    logic       clock = 1'b0;
    logic       rst = 1'b1;
    logic       locked = 1'b0;
    logic       force_relock = 1'b0;
    logic       pll_areset;
    logic       sys_rst;
    logic       ready;
    logic [7:0] lost_lock_count;
    logic [7:0] timeout_count;

    int checks = 0;
    int failures = 0;
    bit modelOn = 1'b0;

    pll_lock_monitor #(
        .ARESET_CYCLES (AR),
        .LOCK_TIMEOUT  (LT),
        .STABLE_CYCLES (SC)
    ) dut (
        .clock           (clock),
        .rst             (rst),
        .locked          (locked),
        .force_relock    (force_relock),
        .pll_areset      (pll_areset),
        .sys_rst         (sys_rst),
        .ready           (ready),
        .lost_lock_count (lost_lock_count),
        .timeout_count   (timeout_count)
    );

    always #5 clock = ~clock;

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs away from the active edge, then settle after it.
    task automatic applyStimulus(input logic r, input logic l, input logic f);
        @(negedge clock);
        rst = r;
        locked = l;
        force_relock = f;
        @(posedge clock);
        #1;
    endtask

    // Reference model: which phase we are in, how long we have been in it,
    // and a two-deep queue standing for the synchronizer delay on locked.
    typedef enum int {M_RESET, M_WAIT, M_STAB, M_RUN} mphase_t;
    mphase_t mPhase, mNext;
    int      mAge, mLost, mTmo;
    bit      mPipe[$];
    bit      mSeen, mTmoEv, mLostEv;

    // Advance the model on each rising edge.
    always @(posedge clock) begin
        if (rst) begin
            mPhase = M_RESET;
            mAge = 0;
            mLost = 0;
            mTmo = 0;
            mPipe = '{1'b0, 1'b0};
        end else begin
            mSeen = mPipe.pop_front();
            mPipe.push_back(locked);
            mNext = mPhase;
            mTmoEv = 1'b0;
            mLostEv = 1'b0;
            if (mPhase == M_RESET && mAge + 1 >= AR) mNext = M_WAIT;
            if (mPhase == M_WAIT) begin
                if (mSeen) mNext = M_STAB;
                else if (mAge + 1 >= LT) begin mNext = M_RESET; mTmoEv = 1'b1; end
            end
            if (mPhase == M_STAB) begin
                if (!mSeen) mNext = M_WAIT;
                else if (mAge + 1 >= SC) mNext = M_RUN;
            end
            if (mPhase == M_RUN && !mSeen) begin mNext = M_WAIT; mLostEv = 1'b1; end
            if (force_relock) begin mNext = M_RESET; mTmoEv = 1'b0; end
            mAge = (force_relock || mNext != mPhase) ? 0 : mAge + 1;
            mPhase = mNext;
            if (mLostEv && mLost < 255) mLost++;
            if (mTmoEv && mTmo < 255) mTmo++;
        end
    end

    // Compare the DUT against the model on every falling edge.
    always @(negedge clock) begin
        if (modelOn) begin
            checkOutput("model_pll_areset", pll_areset, (mPhase == M_RESET));
            checkOutput("model_sys_rst", sys_rst, (mPhase != M_RUN));
            checkOutput("model_ready", ready, (mPhase == M_RUN));
            checkOutput("model_lost_lock_count", lost_lock_count, mLost);
            checkOutput("model_timeout_count", timeout_count, mTmo);
        end
    end

    typedef struct {
        logic r; logic l; logic f;
        logic ea; logic es; logic er;
        int   el; int et;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic l, input logic f,
                                input logic ea, input logic es, input logic er,
                                input int el, input int et);
        vec_t v;
        v = '{r, l, f, ea, es, er, el, et};
        return v;
    endfunction

    vec_t vecs[$];
    int   riseAt[$];
    int   fallAt[$];
    logic prevAreset;
    logic lk;
    int   n;

    // Main stimulus sequence.
    initial begin
        // Reset with lock held, relock timeline, then a one-cycle lock drop in RUN.
        vecs.push_back(mk(1, 1, 0, 1, 1, 0, 0, 0));
        for (int i = 1; i <= 3; i++)  vecs.push_back(mk(0, 1, 0, 1, 1, 0, 0, 0));
        for (int i = 4; i <= 12; i++) vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0));
        for (int i = 13; i <= 15; i++) vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0));
        for (int i = 18; i <= 26; i++) vecs.push_back(mk(0, 1, 0, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0));

        @(posedge clock);
        modelOn = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].r, vecs[i].l, vecs[i].f);
            checkOutput($sformatf("vec%0d_pll_areset", i), pll_areset, vecs[i].ea);
            checkOutput($sformatf("vec%0d_sys_rst", i), sys_rst, vecs[i].es);
            checkOutput($sformatf("vec%0d_ready", i), ready, vecs[i].er);
            checkOutput($sformatf("vec%0d_lost", i), lost_lock_count, vecs[i].el);
            checkOutput($sformatf("vec%0d_timeout", i), timeout_count, vecs[i].et);
        end

        // Forced relock coinciding with the lock loss seen in RUN.
        applyStimulus(0, 0, 0);
        applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 1);
        checkOutput("force_loss_areset", pll_areset, 1);
        checkOutput("force_loss_ready", ready, 0);
        checkOutput("force_loss_lost", lost_lock_count, 2);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(0, 1, 0);
            checkOutput($sformatf("relock_areset_%0d", k), pll_areset, (k < 4));
        end

        // Reset arriving mid-STABILIZE, together with a relock request.
        for (int k = 0; k < 3; k++) applyStimulus(0, 1, 0);
        checkOutput("stab_sys_rst", sys_rst, 1);
        applyStimulus(1, 1, 1);
        checkOutput("midstab_rst_areset", pll_areset, 1);
        checkOutput("midstab_rst_sys_rst", sys_rst, 1);
        checkOutput("midstab_rst_ready", ready, 0);
        checkOutput("midstab_rst_lost", lost_lock_count, 0);
        checkOutput("midstab_rst_timeout", timeout_count, 0);

        // Short lock pulse while waiting for lock must never release sys_rst.
        for (int k = 0; k < 6; k++) applyStimulus(0, 0, 0);
        for (int k = 0; k < 25; k++) begin
            applyStimulus(0, (k < 5), 0);
            checkOutput($sformatf("short_pulse_sys_rst_%0d", k), sys_rst, 1);
        end

        // Edges from the first sampling of locked to ready.
        applyStimulus(1, 0, 0);
        for (int k = 0; k < 6; k++) applyStimulus(0, 0, 0);
        n = 0;
        do begin
            applyStimulus(0, 1, 0);
            n++;
        end while (!ready && n < 40);
        checkOutput("lock_to_ready_edges", n - 1, SC + 2);

        // No lock at all: periodic PLL reset pulses and saturating timeouts.
        applyStimulus(1, 0, 0);
        prevAreset = 1'b1;
        for (int c = 1; c <= 5200; c++) begin
            applyStimulus(0, 0, 0);
            if (pll_areset && !prevAreset) riseAt.push_back(c);
            if (!pll_areset && prevAreset) fallAt.push_back(c);
            prevAreset = pll_areset;
            if (c == 100) checkOutput("timeout_count_c100", timeout_count, 5);
        end
        checkOutput("areset_pulses_seen", (riseAt.size() >= 2 && fallAt.size() >= 2), 1);
        if (riseAt.size() >= 2 && fallAt.size() >= 2) begin
            checkOutput("first_areset_width", fallAt[0], AR);
            checkOutput("areset_width", fallAt[1] - riseAt[0], AR);
            checkOutput("areset_period", riseAt[1] - riseAt[0], AR + LT);
        end
        checkOutput("timeout_count_saturated", timeout_count, 255);

        // Random lock behaviour, relock requests and occasional resets.
        applyStimulus(1, 0, 0);
        lk = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0) lk = ~lk;
            applyStimulus(($urandom_range(0, 399) == 0), lk, ($urandom_range(0, 79) == 0));
        end

        @(negedge clock);
        modelOn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
